// File: rtl/led_pattern_sequencer.sv
// LED bank sequencer: four patterns (blink, chase left/right, ping-pong) stepped at a switch-selected rate.
// Switch-to-effect latency 2 cycles; no backpressure, LEDR/mode change the cycle after tick.
module led_pattern_sequencer #(
  parameter int DIV0 = 50_000_000,
  parameter int DIV1 = 25_000_000,
  parameter int DIV2 = 10_000_000,
  parameter int DIV3 = 5_000_000
) (
  input  logic       CLOCK_50,
  input  logic       reset,
  input  logic [9:0] SW,
  output logic [9:0] LEDR,
  output logic [1:0] mode,
  output logic       tick
);

  localparam int DIV_MAX01 = (DIV0 > DIV1) ? DIV0 : DIV1;
  localparam int DIV_MAX23 = (DIV2 > DIV3) ? DIV2 : DIV3;
  localparam int DIV_MAX   = (DIV_MAX01 > DIV_MAX23) ? DIV_MAX01 : DIV_MAX23;
  localparam int CW        = $clog2(DIV_MAX);

  typedef enum logic [1:0] {
    BLINK    = 2'b00,
    LEFT     = 2'b01,
    RIGHT    = 2'b10,
    PINGPONG = 2'b11
  } mode_e;

  // Only pause, mode request and rate bits are used; SW[8:4] are don't-care.
  logic [4:0]    r_sw_meta;
  logic [4:0]    r_sw_s;
  logic [1:0]    r_rate;
  logic [CW-1:0] r_cnt;
  logic          r_tick;
  mode_e         r_mode;
  logic [9:0]    r_ledr;
  logic          r_dir_up;

  logic [CW-1:0] w_last;
  logic          w_pause;
  logic [1:0]    w_rate_req;
  mode_e         w_mode_req;
  logic          w_onehot;
  logic          w_unused_sw;

  assign w_unused_sw = ^SW[8:4];
  assign w_pause     = r_sw_s[4];
  assign w_mode_req  = mode_e'(r_sw_s[3:2]);
  assign w_rate_req  = r_sw_s[1:0];
  assign w_onehot    = (r_ledr != 10'h000) && ((r_ledr & (r_ledr - 10'h001)) == 10'h000);

  always_comb begin
    w_last = CW'(DIV0 - 1);
    case (w_rate_req)
      2'b00: w_last = CW'(DIV0 - 1);
      2'b01: w_last = CW'(DIV1 - 1);
      2'b10: w_last = CW'(DIV2 - 1);
      2'b11: w_last = CW'(DIV3 - 1);
      default: w_last = CW'(DIV0 - 1);
    endcase
  end

  function automatic logic [9:0] init_of(input mode_e m);
    case (m)
      BLINK:    init_of = 10'h3FF;
      LEFT:     init_of = 10'h001;
      RIGHT:    init_of = 10'h200;
      PINGPONG: init_of = 10'h001;
      default:  init_of = 10'h000;
    endcase
  endfunction

  // A rate change outranks both pause and a terminal count: the new period starts from zero.
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      r_sw_meta <= '0;
      r_sw_s    <= '0;
      r_rate    <= '0;
      r_cnt     <= '0;
      r_tick    <= 1'b0;
    end else begin
      r_sw_meta <= {SW[9], SW[3:0]};
      r_sw_s    <= r_sw_meta;
      r_rate    <= w_rate_req;
      r_tick    <= 1'b0;
      if (w_rate_req != r_rate) begin
        r_cnt <= '0;
      end else if (!w_pause) begin
        if (r_cnt == w_last) begin
          r_cnt  <= '0;
          r_tick <= 1'b1;
        end else begin
          r_cnt <= r_cnt + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      r_mode   <= BLINK;
      r_ledr   <= 10'h000;
      r_dir_up <= 1'b1;
    end else if (r_tick && !w_pause) begin
      if (w_mode_req != r_mode) begin
        r_mode   <= w_mode_req;
        r_ledr   <= init_of(w_mode_req);
        r_dir_up <= 1'b1;
      end else begin
        case (r_mode)
          BLINK: r_ledr <= ~r_ledr;
          LEFT:  r_ledr <= w_onehot ? {r_ledr[8:0], r_ledr[9]} : 10'h001;
          RIGHT: r_ledr <= w_onehot ? {r_ledr[0], r_ledr[9:1]} : 10'h200;
          PINGPONG: begin
            // Reverse without revisiting the endpoint, so 200 and 001 each show once per sweep.
            if (!w_onehot) begin
              r_ledr   <= 10'h001;
              r_dir_up <= 1'b1;
            end else if (r_dir_up) begin
              if (r_ledr[9]) begin
                r_ledr   <= 10'h100;
                r_dir_up <= 1'b0;
              end else begin
                r_ledr <= r_ledr << 1;
              end
            end else begin
              if (r_ledr[0]) begin
                r_ledr   <= 10'h002;
                r_dir_up <= 1'b1;
              end else begin
                r_ledr <= r_ledr >> 1;
              end
            end
          end
          default: r_ledr <= r_ledr;
        endcase
      end
    end
  end

  assign LEDR = r_ledr;
  assign mode = r_mode;
  assign tick = r_tick;

endmodule

// File: tb/tb_led_pattern_sequencer.sv
// Directed bench for led_pattern_sequencer with small dividers (4, 6, 3, 2).
module tb_led_pattern_sequencer;

  logic       clk;
  logic       reset;
  logic [9:0] SW;
  logic [9:0] LEDR;
  logic [1:0] mode;
  logic       tick;

  int n_checks = 0;
  int n_fail   = 0;

  led_pattern_sequencer #(.DIV0(4), .DIV1(6), .DIV2(3), .DIV3(2)) dut (
    .CLOCK_50 (clk),
    .reset    (reset),
    .SW       (SW),
    .LEDR     (LEDR),
    .mode     (mode),
    .tick     (tick)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [9:0] ledr;
    logic [1:0] mode;
    logic [9:0] sw;
    int         wt;
  } vec_t;

  vec_t tbl[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Counts negedges until tick is seen; an expired budget shows up as a wrong count.
  task automatic wait_tick(input int exp, input string name);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!tick && n < 40);
    check(name, n, exp);
  endtask

  task automatic check_step(input string name, input logic [9:0] ledr, input logic [1:0] md);
    @(negedge clk);
    check({name, "_ledr"}, LEDR, ledr);
    check({name, "_mode"}, mode, md);
    check({name, "_tick"}, tick, 1'b0);
  endtask

  initial begin
    logic [9:0] exp_r;
    // Blink, then 00->01 rate change that collides with a terminal count.
    tbl.push_back('{10'h3FF, 2'd0, 10'h000, 3});
    tbl.push_back('{10'h000, 2'd0, 10'h001, 9});
    tbl.push_back('{10'h3FF, 2'd0, 10'h001, 5});
    tbl.push_back('{10'h000, 2'd0, 10'h007, 5});
    // Left chase at P=2, including the 200 -> 001 wrap.
    tbl.push_back('{10'h001, 2'd1, 10'h007, 1});
    tbl.push_back('{10'h002, 2'd1, 10'h007, 1});
    tbl.push_back('{10'h004, 2'd1, 10'h007, 1});
    tbl.push_back('{10'h008, 2'd1, 10'h007, 1});
    tbl.push_back('{10'h010, 2'd1, 10'h007, 1});
    tbl.push_back('{10'h020, 2'd1, 10'h007, 1});
    tbl.push_back('{10'h040, 2'd1, 10'h007, 1});
    tbl.push_back('{10'h080, 2'd1, 10'h007, 1});
    tbl.push_back('{10'h100, 2'd1, 10'h007, 1});
    tbl.push_back('{10'h200, 2'd1, 10'h007, 1});
    tbl.push_back('{10'h001, 2'd1, 10'h00F, 1});
    // Request reaches sw_s one step late at P=2, so one more left shift first.
    tbl.push_back('{10'h002, 2'd1, 10'h00F, 1});
    tbl.push_back('{10'h001, 2'd3, 10'h00F, 1});
    tbl.push_back('{10'h002, 2'd3, 10'h00F, 1});
    tbl.push_back('{10'h004, 2'd3, 10'h00F, 1});
    tbl.push_back('{10'h008, 2'd3, 10'h00F, 1});
    tbl.push_back('{10'h010, 2'd3, 10'h00F, 1});
    tbl.push_back('{10'h020, 2'd3, 10'h00F, 1});
    tbl.push_back('{10'h040, 2'd3, 10'h00F, 1});
    tbl.push_back('{10'h080, 2'd3, 10'h00F, 1});
    tbl.push_back('{10'h100, 2'd3, 10'h00F, 1});
    tbl.push_back('{10'h200, 2'd3, 10'h00F, 1});
    tbl.push_back('{10'h100, 2'd3, 10'h00F, 1});
    tbl.push_back('{10'h080, 2'd3, 10'h00F, 1});
    tbl.push_back('{10'h040, 2'd3, 10'h00F, 1});
    tbl.push_back('{10'h020, 2'd3, 10'h00F, 1});
    tbl.push_back('{10'h010, 2'd3, 10'h00F, 1});
    tbl.push_back('{10'h008, 2'd3, 10'h00F, 1});
    tbl.push_back('{10'h004, 2'd3, 10'h00F, 1});
    tbl.push_back('{10'h002, 2'd3, 10'h00F, 1});
    tbl.push_back('{10'h001, 2'd3, 10'h00F, 1});
    tbl.push_back('{10'h002, 2'd3, 10'h005, 1});
    // Rate 11->01: the pending tick at the change is suppressed, then P=6.
    tbl.push_back('{10'h004, 2'd3, 10'h005, 7});
    tbl.push_back('{10'h001, 2'd1, 10'h005, 5});
    tbl.push_back('{10'h002, 2'd1, 10'h005, 5});
    tbl.push_back('{10'h004, 2'd1, 10'h005, 5});
    tbl.push_back('{10'h008, 2'd1, 10'h005, 5});

    SW    = 10'h000;
    reset = 1'b1;
    repeat (2) @(negedge clk);
    check("reset_ledr", LEDR, 10'h000);
    check("reset_mode", mode, 2'd0);
    check("reset_tick", tick, 1'b0);
    reset = 1'b0;
    wait_tick(4, "first_tick");

    for (int i = 0; i < tbl.size(); i++) begin
      check_step($sformatf("vec%0d", i), tbl[i].ledr, tbl[i].mode);
      SW = tbl[i].sw;
      wait_tick(tbl[i].wt, $sformatf("vec%0d_wait", i));
    end

    // Pause for 20+ cycles at count 3 of 6: everything frozen, then 2 remaining counts + sync.
    check_step("pause_entry", 10'h010, 2'd1);
    SW = 10'h205;
    for (int k = 0; k < 22; k++) begin
      @(negedge clk);
      check($sformatf("pause%0d", k), {tick, mode, LEDR}, {1'b0, 2'd1, 10'h010});
    end
    SW = 10'h005;
    wait_tick(5, "pause_release_wait");

    // One-cycle reset while in LEFT at 010 overrides the pending step.
    reset = 1'b1;
    SW    = 10'h004;
    @(negedge clk);
    check("midreset_ledr", LEDR, 10'h000);
    check("midreset_mode", mode, 2'd0);
    check("midreset_tick", tick, 1'b0);
    reset = 1'b0;
    wait_tick(4, "midreset_wait");
    check_step("midreset_step", 10'h001, 2'd1);

    // Right chase at P=2, through the 001 -> 200 wrap.
    SW = 10'h00B;
    wait_tick(5, "right_wait");
    exp_r = 10'h200;
    for (int k = 0; k < 11; k++) begin
      check_step($sformatf("right%0d", k), exp_r, 2'd2);
      wait_tick(1, $sformatf("right%0d_wait", k));
      exp_r = {exp_r[0], exp_r[9:1]};
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

endmodule
